// File: rtl/probe_mem_arbiter.sv
// probe_mem_arbiter: round-robin share of one memory-controller read port among NUM_REQ probe requesters, with credit-limited outstanding reads and flush/drain done
//   clk, rst (sync, active-high)
//   rq_vld/rq_addr/rq_rdy             : per-requester request handshake
//   mc_rq_vld/mc_rq_addr/mc_rq_src    : registered request to controller, held while mc_rq_stall
//   mc_rs_vld/mc_rs_src -> rs_vld     : registered one-hot response routing
//   flush -> done                     : RUN -> DRAIN -> DONE once all issued reads are answered
//   outstanding                       : in-flight count, saturating at 0
//   err (only with PROBE_ARB_ERR_CHECK_EN): sticky flag for spurious or out-of-range responses
module probe_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 48,
  parameter int SRC_W   = 3,
  parameter int MAX_OUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        rq_vld,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_addr,
  output logic [NUM_REQ-1:0]        rq_rdy,
  output logic                      mc_rq_vld,
  output logic [ADDR_W-1:0]         mc_rq_addr,
  output logic [SRC_W-1:0]          mc_rq_src,
  input  logic                      mc_rq_stall,
  input  logic                      mc_rs_vld,
  input  logic [SRC_W-1:0]          mc_rs_src,
  output logic [NUM_REQ-1:0]        rs_vld,
  input  logic                      flush,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      done
`ifdef PROBE_ARB_ERR_CHECK_EN
  ,
  output logic                      err
`endif
);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;
  logic [SRC_W-1:0] ptr, gnt;
  logic gnt_vld, accept;
  logic [CNT_W-1:0] out_nxt;
  // first valid requester at or after the pointer, wrapping
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (!gnt_vld && rq_vld[(int'(ptr) + i) % NUM_REQ]) begin
        gnt_vld = 1'b1;
        gnt = SRC_W'((int'(ptr) + i) % NUM_REQ);
      end
  end
  always_comb begin
    accept = gnt_vld && state == S_RUN && !mc_rq_stall && outstanding < CNT_W'(MAX_OUT) && !rst;
    rq_rdy = accept ? NUM_REQ'(1) << gnt : '0;
    // a response with nothing in flight cannot underflow the counter
    out_nxt = (accept && !mc_rs_vld) ? outstanding + CNT_W'(1) :
              (!accept && mc_rs_vld && outstanding != '0) ? outstanding - CNT_W'(1) : outstanding;
    state_nxt = (state == S_RUN && flush) ? S_DRAIN :
                (state == S_DRAIN && outstanding == '0 && !mc_rq_vld) ? S_DONE : state;
  end
  assign done = state == S_DONE;
  always_ff @(posedge clk)
    if (rst) begin
      state       <= S_RUN;
      ptr         <= '0;
      outstanding <= '0;
      mc_rq_vld   <= 1'b0;
      mc_rq_addr  <= '0;
      mc_rq_src   <= '0;
      rs_vld      <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      // out-of-range sources shift out of the one-hot and are dropped
      rs_vld      <= mc_rs_vld ? NUM_REQ'(1) << mc_rs_src : '0;
      if (!mc_rq_stall) mc_rq_vld <= accept;
      if (accept) begin
        mc_rq_addr <= rq_addr[int'(gnt)*ADDR_W +: ADDR_W];
        mc_rq_src  <= gnt;
        ptr        <= (gnt == SRC_W'(NUM_REQ - 1)) ? '0 : gnt + SRC_W'(1);
      end
    end
`ifdef PROBE_ARB_ERR_CHECK_EN
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else if (mc_rs_vld && (outstanding == '0 || {1'b0, mc_rs_src} >= (SRC_W+1)'(NUM_REQ))) err <= 1'b1;
`endif
endmodule

// File: tb/tb_probe_mem_arbiter.sv
// tb_probe_mem_arbiter: scoreboard bench for probe_mem_arbiter (NUM_REQ=2, MAX_OUT=6)
module tb_probe_mem_arbiter;
  localparam int N = 2, AW = 48, SW = 3, MO = 6, CW = 7;
  localparam logic [AW-1:0] A0 = 48'h0000_AAAA_0000, A1 = 48'h1111_BBBB_0001, B0 = 48'h2222_CCCC_0002;
  logic clk = 1'b0;
  logic rst, mc_rq_vld, mc_rq_stall, mc_rs_vld, flush, done;
  logic [N-1:0] rq_vld, rq_rdy, rs_vld;
  logic [N*AW-1:0] rq_addr;
  logic [AW-1:0] mc_rq_addr;
  logic [SW-1:0] mc_rq_src, mc_rs_src;
  logic [CW-1:0] outstanding;
`ifdef PROBE_ARB_ERR_CHECK_EN
  logic err;
`endif
  int n_vec = 0, n_err = 0;
  logic [63:0] beat_q[$], rs_q[$];
  always #5 clk = ~clk;
  probe_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .SRC_W(SW), .MAX_OUT(MO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rq_vld(rq_vld), .rq_addr(rq_addr), .rq_rdy(rq_rdy),
    .mc_rq_vld(mc_rq_vld), .mc_rq_addr(mc_rq_addr), .mc_rq_src(mc_rq_src), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_src(mc_rs_src), .rs_vld(rs_vld), .flush(flush),
    .outstanding(outstanding), .done(done)
`ifdef PROBE_ARB_ERR_CHECK_EN
    , .err(err)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic push_beat(input logic [SW-1:0] s, input logic [AW-1:0] a);
    beat_q.push_back({13'b0, s, a});
  endtask
  task automatic rsp(input logic v, input logic [SW-1:0] s);
    mc_rs_vld = v;
    mc_rs_src = s;
    if (v && s < N) rs_q.push_back(64'(1) << s);
  endtask
  // a beat is consumed on an edge where it is valid and not stalled
  always @(negedge clk) begin
    if (mc_rq_vld === 1'b1 && mc_rq_stall === 1'b0) begin
      chk("beat_expected", 64'(beat_q.size() != 0), 64'(1));
      if (beat_q.size() != 0) chk("beat", {13'b0, mc_rq_src, mc_rq_addr}, beat_q.pop_front());
    end
    if (|rs_vld === 1'b1) begin
      chk("rs_expected", 64'(rs_q.size() != 0), 64'(1));
      if (rs_q.size() != 0) chk("rs_vld", 64'(rs_vld), rs_q.pop_front());
    end
  end
  initial begin
    int exp_out, zero_at;
    rst = 1'b1; rq_vld = '0; rq_addr = {A1, A0}; mc_rq_stall = 1'b0;
    mc_rs_vld = 1'b0; mc_rs_src = '0; flush = 1'b0;
    step;
    rq_vld = 2'b11;
    #1 chk("rst_rdy", 64'(rq_rdy), 0);
    step;
    chk("rst_mc_vld", 64'(mc_rq_vld), 0);
    chk("rst_mc_addr", 64'(mc_rq_addr), 0);
    chk("rst_mc_src", 64'(mc_rq_src), 0);
    chk("rst_rs_vld", 64'(rs_vld), 0);
    chk("rst_out", 64'(outstanding), 0);
    chk("rst_done", 64'(done), 0);
`ifdef PROBE_ARB_ERR_CHECK_EN
    chk("rst_err", 64'(err), 0);
`endif
    rst = 1'b0;
    // round robin alternation until credits run out
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_rdy", 64'(rq_rdy), 64'(1) << (i % 2));
      push_beat(SW'(i % 2), (i % 2) ? A1 : A0);
      step;
    end
    chk("rr_out", 64'(outstanding), 6);
    #1 chk("rr_full_rdy", 64'(rq_rdy), 0);
    // credit limit: one response frees exactly one accept
    rq_vld = 2'b01;
    #1 chk("cr_full_rdy", 64'(rq_rdy), 0);
    step; step;
    chk("cr_held", 64'(outstanding), 6);
    rsp(1'b1, 0);
    #1 chk("cr_rdy_same", 64'(rq_rdy), 0);
    step;
    rsp(1'b0, 0);
    chk("cr_freed", 64'(outstanding), 5);
    #1 chk("cr_rdy_after", 64'(rq_rdy), 2'b01);
    push_beat(0, A0);
    step;
    chk("cr_refull", 64'(outstanding), 6);
    #1 chk("cr_rdy_refull", 64'(rq_rdy), 0);
    rq_vld = '0;
    // stall holds the pending beat
    for (int i = 0; i < 3; i++) begin
      rsp(1'b1, 1);
      step;
    end
    rsp(1'b0, 0);
    chk("st_out_pre", 64'(outstanding), 3);
    rq_addr = {A1, B0};
    rq_vld = 2'b01;
    push_beat(0, B0);
    step;
    chk("st_out_acc", 64'(outstanding), 4);
    mc_rq_stall = 1'b1;
    rq_vld = 2'b11;
    #1 chk("st_rdy", 64'(rq_rdy), 0);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("st_vld", 64'(mc_rq_vld), 1);
      chk("st_addr", 64'(mc_rq_addr), 64'(B0));
      chk("st_src", 64'(mc_rq_src), 0);
      chk("st_out", 64'(outstanding), 4);
      chk("st_rdy_hold", 64'(rq_rdy), 0);
    end
    mc_rq_stall = 1'b0;
    rq_vld = '0;
    step;
    chk("st_out_post", 64'(outstanding), 4);
    // accept and response together, then an out-of-range response
    rsp(1'b1, 0);
    step;
    rsp(1'b0, 0);
    chk("sim_out_pre", 64'(outstanding), 3);
    rq_vld = 2'b10;
    rsp(1'b1, 1);
    push_beat(1, A1);
    #1 chk("sim_rdy", 64'(rq_rdy), 2'b10);
    step;
    rq_vld = '0;
    rsp(1'b0, 0);
    chk("sim_out", 64'(outstanding), 3);
    chk("sim_rs", 64'(rs_vld), 2'b10);
    rsp(1'b1, 2);
    step;
    rsp(1'b0, 0);
    chk("drop_out", 64'(outstanding), 2);
    chk("drop_rs", 64'(rs_vld), 0);
    // flush and drain
    rq_vld = 2'b11;
    for (int i = 0; i < 3; i++) begin
      push_beat(SW'(i % 2), (i % 2) ? A1 : B0);
      step;
    end
    chk("fl_out", 64'(outstanding), 5);
    rq_vld = '0;
    flush = 1'b1;
    step;
    flush = 1'b0;
    rq_vld = 2'b11;
    exp_out = 5;
    zero_at = -1;
    for (int j = 0; j < 10; j++) begin
      rsp(j % 2 == 0, (j % 4 == 0) ? 0 : 1);
      #1 chk("dr_rdy", 64'(rq_rdy), 0);
      step;
      if (j % 2 == 0) exp_out--;
      if (exp_out == 0 && zero_at < 0) zero_at = j;
      chk("dr_out", 64'(outstanding), 64'(exp_out));
      chk("dr_done", 64'(done), 64'(zero_at >= 0 && j > zero_at));
    end
    rsp(1'b0, 0);
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      flush = 1'b0;
      chk("done_hold", 64'(done), 1);
      chk("done_rdy", 64'(rq_rdy), 0);
    end
    // spurious response at zero saturates
    rsp(1'b1, 0);
    step;
    rsp(1'b0, 0);
    chk("sat_out", 64'(outstanding), 0);
`ifdef PROBE_ARB_ERR_CHECK_EN
    chk("err_set", 64'(err), 1);
`endif
    step; step;
`ifdef PROBE_ARB_ERR_CHECK_EN
    chk("err_sticky", 64'(err), 1);
`endif
    // reset mid-operation
    rst = 1'b1;
    rq_vld = 2'b01;
    #1 chk("mr_rdy", 64'(rq_rdy), 0);
    step;
    chk("mr_done", 64'(done), 0);
    chk("mr_out", 64'(outstanding), 0);
    chk("mr_mc_vld", 64'(mc_rq_vld), 0);
`ifdef PROBE_ARB_ERR_CHECK_EN
    chk("mr_err", 64'(err), 0);
`endif
    rst = 1'b0;
    rq_vld = '0;
    rsp(1'b1, 1);
    step;
    rsp(1'b0, 0);
    chk("mr_rs_out", 64'(outstanding), 0);
    chk("mr_rs", 64'(rs_vld), 2'b10);
    rq_vld = 2'b01;
    #1 chk("mr_run_rdy", 64'(rq_rdy), 2'b01);
    push_beat(0, B0);
    step;
    rq_vld = '0;
    step;
    chk("mr_run_out", 64'(outstanding), 1);
    step;
    chk("beat_q_empty", 64'(beat_q.size()), 0);
    chk("rs_q_empty", 64'(rs_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
